// File: rtl/lfsr_rng.sv
// lfsr_rng: parametrised Fibonacci LFSR with seed load, free-run stepping and
// a req/valid draw port returning an unbiased value in [0, limit) by masked
// rejection sampling with a bounded number of retries.
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_seed_load  load i_seed into the state (zero seed substitutes SEED)
//   i_seed       seed value
//   i_free_run   step the LFSR every cycle while not drawing
//   i_req        draw request, sampled only in IDLE
//   i_limit      exclusive upper bound, captured on accept
//   o_valid      one-cycle pulse, o_value is a fresh draw
//   o_value      drawn number, held until the next valid
//   o_busy       high while a draw is in flight (DRAW and DONE)
//   o_state      current LFSR state
module lfsr_rng #(
  parameter int unsigned           WIDTH     = 16,
  parameter logic [WIDTH-1:0]      TAPS      = WIDTH'(16'hD008),
  parameter logic [WIDTH-1:0]      SEED      = WIDTH'(1),
  parameter int unsigned           OUT_W     = 8,
  parameter int unsigned           MAX_TRIES = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_free_run,
  input  logic             i_req,
  input  logic [OUT_W-1:0] i_limit,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_value,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_state
);

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t             r_fsm, w_fsm_nxt;
  logic [WIDTH-1:0] r_state, w_state_nxt, w_step;
  logic [OUT_W-1:0] r_lim, w_lim_nxt;
  logic [OUT_W-1:0] r_mask, w_mask_nxt;
  logic [OUT_W-1:0] r_value, w_value_nxt;
  logic [TRY_W-1:0] r_tries, w_tries_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_fb, w_do_step;
  logic [OUT_W-1:0] w_smear, w_mask_acc, w_cand;

  // Feedback and next LFSR value
  always_comb begin
    w_fb   = ^(r_state & TAPS);
    w_step = {r_state[WIDTH-2:0], w_fb};
  end

  // Smallest all-ones mask covering limit-1; zero for limit 0 or 1
  always_comb begin
    w_smear = i_limit - OUT_W'(1);
    for (int i = 1; i < OUT_W; i++) begin
      w_smear = w_smear | (w_smear >> i);
    end
    w_mask_acc = (i_limit <= OUT_W'(1)) ? '0 : w_smear;
    w_cand     = r_state[OUT_W-1:0] & r_mask;
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_fsm <= IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  // Next-state, draw datapath and LFSR update
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_lim_nxt   = r_lim;
    w_mask_nxt  = r_mask;
    w_tries_nxt = r_tries;
    w_value_nxt = r_value;
    w_do_step   = 1'b0;
    case (r_fsm)
      IDLE: begin
        w_do_step = i_free_run;
        if (i_req) begin
          w_lim_nxt   = i_limit;
          w_mask_nxt  = w_mask_acc;
          w_tries_nxt = '0;
          w_fsm_nxt   = DRAW;
        end
      end
      DRAW: begin
        w_do_step = 1'b1;
        if (r_lim <= OUT_W'(1)) begin
          w_value_nxt = '0;
          w_fsm_nxt   = DONE;
        end else if (w_cand < r_lim) begin
          w_value_nxt = w_cand;
          w_fsm_nxt   = DONE;
        end else if (r_tries == TRY_W'(MAX_TRIES - 1)) begin
          // mask < 2*lim, so a rejected candidate minus lim is in range
          w_value_nxt = w_cand - r_lim;
          w_fsm_nxt   = DONE;
        end else begin
          w_tries_nxt = r_tries + TRY_W'(1);
        end
      end
      DONE: begin
        w_do_step = i_free_run;
        w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase

    if (i_seed_load)    w_state_nxt = (i_seed == '0) ? SEED : i_seed;
    else if (w_do_step) w_state_nxt = w_step;
    else                w_state_nxt = r_state;

    w_valid_nxt = (w_fsm_nxt == DONE);
    w_busy_nxt  = (w_fsm_nxt != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SEED;
      r_lim   <= '0;
      r_mask  <= '0;
      r_tries <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lim   <= w_lim_nxt;
      r_mask  <= w_mask_nxt;
      r_tries <= w_tries_nxt;
      r_value <= w_value_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_value = r_value;
  assign o_busy  = r_busy;
  assign o_state = r_state;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: directed bench for lfsr_rng with an 8-bit x^8+x^6+x^5+x^4+1
// LFSR. Instance 0 uses MAX_TRIES=8, instance 1 MAX_TRIES=1; both share stimulus.
module tb_lfsr_rng;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seed_load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       free_run = 1'b0;
  logic       req = 1'b0;
  logic [7:0] limit = 8'h00;

  logic       valid0, busy0, valid1, busy1;
  logic [7:0] value0, state0, value1, state1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] val;
    int         lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  lfsr_rng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .OUT_W(8), .MAX_TRIES(8)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_seed_load(seed_load), .i_seed(seed),
    .i_free_run(free_run), .i_req(req), .i_limit(limit),
    .o_valid(valid0), .o_value(value0), .o_busy(busy0), .o_state(state0)
  );

  lfsr_rng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .OUT_W(8), .MAX_TRIES(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_seed_load(seed_load), .i_seed(seed),
    .i_free_run(free_run), .i_req(req), .i_limit(limit),
    .o_valid(valid1), .o_value(value1), .o_busy(busy1), .o_state(state1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  task automatic load_seed(input logic [7:0] s);
    seed_load = 1'b1;
    seed      = s;
    tick();
    seed_load = 1'b0;
  endtask

  // Issue one draw and check latency/value against the scoreboard entry
  task automatic do_draw(input string tag, input bit sel, input logic [7:0] lim,
                         input logic [7:0] exp_val, input int exp_lat);
    int   lat;
    exp_t e;
    exp_q.push_back('{val: exp_val, lat: exp_lat});
    req   = 1'b1;
    limit = lim;
    tick();
    req = 1'b0;
    lat = 1;
    chk({tag, "_busy_n1"}, sel ? busy1 : busy0, 1);
    while (!(sel ? valid1 : valid0) && lat < 20) begin
      tick();
      lat++;
    end
    e = exp_q.pop_front();
    chk({tag, "_valid"}, sel ? valid1 : valid0, 1);
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_value"}, sel ? value1 : value0, e.val);
    chk({tag, "_busy_done"}, sel ? busy1 : busy0, 1);
    tick();
    chk({tag, "_pulse"}, sel ? valid1 : valid0, 0);
    chk({tag, "_hold"}, sel ? value1 : value0, e.val);
  endtask

  initial begin
    logic [7:0] exp_seq[4];
    int         first_ret;
    bit         zero_seen;
    logic [7:0] vmask;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", state0, 8'h01);
    chk("rst_valid", valid0, 0);
    chk("rst_value", value0, 0);
    chk("rst_busy", busy0, 0);

    // Free-run sequence and period
    exp_seq  = '{8'h02, 8'h04, 8'h08, 8'h11};
    free_run = 1'b1;
    first_ret = 0;
    zero_seen = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i <= 4) chk($sformatf("free_run_%0d", i), state0, exp_seq[i-1]);
      if (state0 == 8'h00) zero_seen = 1'b1;
      if (state0 == 8'h01 && first_ret == 0) first_ret = i;
    end
    chk("period", first_ret, 255);
    chk("no_zero", zero_seen, 0);
    free_run = 1'b0;
    tick();
    chk("free_run_off_hold", state0, 8'h01);

    // Accepted on first candidate: 0x11 & 7 = 1
    load_seed(8'h11);
    chk("seed_0x11", state0, 8'h11);
    do_draw("s2", 1'b0, 8'd6, 8'd1, 2);

    // Candidates 7 and 6 rejected, 5 accepted
    repeat (3) tick();
    load_seed(8'h07);
    do_draw("s3", 1'b0, 8'd6, 8'd5, 4);
    chk("s3_state_after", state0, 8'h3A);

    // Single-try fallback 7-6
    repeat (4) tick();
    load_seed(8'h07);
    do_draw("s4", 1'b1, 8'd6, 8'd1, 2);
    repeat (4) tick();

    // Zero seed substitution and degenerate limits
    load_seed(8'h00);
    chk("zero_seed", state0, 8'h01);
    do_draw("lim0", 1'b0, 8'd0, 8'd0, 2);
    do_draw("lim1", 1'b0, 8'd1, 8'd0, 2);

    // Full-range limit: lim=255, mask=255; state after two draws is 0x04
    chk("pre_lim255_state", state0, 8'h04);
    do_draw("lim255", 1'b0, 8'd255, 8'd4, 2);

    // Reset during DRAW drops the draw
    load_seed(8'h07);
    req   = 1'b1;
    limit = 8'd6;
    tick();
    req = 1'b0;
    chk("s6_busy_draw", busy0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_busy", busy0, 0);
    chk("s6_state", state0, 8'h01);
    chk("s6_valid", valid0, 0);
    chk("s6_value", value0, 0);
    vmask = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid0) vmask[i] = 1'b1;
    end
    chk("s6_no_valid", vmask, 0);

    // Held req: serviced at N+2, re-accepted from IDLE at N+3, valid at N+5
    load_seed(8'h11);
    req   = 1'b1;
    limit = 8'd6;
    vmask = '0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (valid0) vmask[i] = 1'b1;
      if (i == 2) chk("held_first_value", value0, 1);
      if (i == 5) chk("held_second_value", value0, 3);
    end
    req = 1'b0;
    chk("held_valid_pattern", vmask, 8'h24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
Parametrised Fibonacci LFSR random source for game logic such as encounter rolls, damage variance and AI choice. It extends the fixed 8-bit free-running LFSR with several additions:
- configurable width and tap mask
- runtime seed load, with zero-seed protection
- free-run stepping
- a req/valid draw port that returns an unbiased value in [0, limit) using masked rejection sampling with a bounded retry count.

Parameters:
WIDTH, 16, LFSR state width (4..32).
TAPS, 16'hD008, feedback mask; bit i set means state[i] is XORed into feedback (default = x^16+x^15+x^13+x^4+1, maximal length).
SEED, 1, reset and zero-substitute state; must be nonzero.
OUT_W, 8, draw limit/value width (OUT_W <= WIDTH).
MAX_TRIES, 8, rejection attempts before fallback (>= 1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
seed_load  in  1  load seed into state this cycle
seed  in  WIDTH  seed value
free_run  in  1  step the LFSR every cycle while not drawing
req  in  1  draw request; sampled only in IDLE
limit  in  OUT_W  exclusive upper bound for the draw; captured on accept
valid  out  1  one-cycle pulse, value is valid
value  out  OUT_W  drawn number, held until the next valid
busy  out  1  high in DRAW and DONE
state  out  WIDTH  current LFSR state

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Step rule: fb = ^(state & TAPS); state <= {state[WIDTH-2:0], fb}.
- Reset values: state=SEED, FSM=IDLE, valid=0, value=0, busy=0, tries=0.
- Priority: rst > seed_load > step.
  - seed_load with seed==0 loads SEED instead, so the state is never all-zero.
  - seed_load in DRAW replaces the state; the draw continues from the new state next cycle (no abort).
- Stepping: always in DRAW; in IDLE/DONE only when free_run=1.
- FSM IDLE:
  - On req=1, capture lim=limit.
  - Compute mask = (2^k)-1, the smallest such value >= lim-1 (mask=0 for lim<=1).
  - Set tries=0 and go to DRAW.
  - A req arriving while busy is ignored, not queued.
- FSM DRAW: each cycle compute cand = state[OUT_W-1:0] & mask from the pre-step state.
  - lim<=1: value<=0, go DONE.
  - cand < lim: value<=cand, go DONE.
  - otherwise, if tries==MAX_TRIES-1: value<=cand-lim (always < lim because mask < 2*lim), go DONE.
  - otherwise tries++ and stay in DRAW.
  - The LFSR steps every DRAW cycle regardless of the outcome.
- FSM DONE: valid=1 for exactly this cycle, then go to IDLE.
  - Minimum latency: req in cycle N, valid in N+2.
  - Maximum latency: N+1+MAX_TRIES.
- value holds its last result outside valid cycles.
- busy=1 in DRAW and DONE; a new req is accepted no earlier than the cycle after DONE.
- rst in any state returns to IDLE immediately with all outputs at their reset values; an in-flight draw is dropped and no valid is produced.
- Period: with maximal TAPS the state sequence has period 2^WIDTH-1 and never reaches 0.

Test Plan:
1. WIDTH=8, TAPS=8'hB8, rst then free_run=1 -> state 0x01,0x02,0x04,0x08,0x11, and returns to 0x01 after exactly 255 steps; 0x00 never appears.
2. WIDTH=8, TAPS=8'hB8, free_run=0, seed_load seed=0x11, then req limit=6 at cycle N -> valid at N+2 with value=1; busy high for N+1..N+2.
3. Same config, seed=0x07, req limit=6 -> candidates 7 and 6 rejected, state 0x07->0x0E->0x1D, value=5, valid at N+4.
4. Scenario 3 with MAX_TRIES=1 -> fallback value=7-6=1, valid at N+2.
5. seed_load seed=0 -> state=SEED (0x01); req limit=0 and req limit=1 -> value=0 at N+2 for both.
6. Assert rst during DRAW -> next cycle FSM=IDLE, busy=0, state=SEED, no valid pulse. A req held during busy is not serviced until it is re-presented after DONE.
